usb_rx_decoder: RTL and testbench



---
 rtl/usb_rx_pkg.sv | 26 ++
 rtl/usb_rx_bit_sampler.sv | 88 ++++++++
 rtl/usb_rx_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_usb_rx_decoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the full-speed USB receive decoder.
// Line states are encoded as {d_plus, d_minus}.
package usb_rx_pkg;

  localparam int unsigned LINE_W      = 2;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned STUFF_LIMIT = 6;
  localparam int unsigned ERR_J_EXIT  = 8;

  typedef logic [LINE_W-1:0] line_t;

  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_RECV,
    ST_EOP,
    ST_ERR
  } rx_state_e;

endpackage

// File: rtl/usb_rx_bit_sampler.sv
// Synchronizes D+/D-, recovers bit timing from J<->K transitions and NRZI-decodes
// one sample per bit time. All outputs are registered single-cycle qualifiers.
module usb_rx_bit_sampler
  import usb_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus_i,
  input  logic d_minus_i,
  output logic bit_strobe_o,
  output logic bit_value_o,
  output logic se0_sample_o,
  output logic j_sample_o
);

  localparam int unsigned PHASE_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned SAMPLE_AT  = CLKS_PER_BIT / 2 - 1;
  localparam int unsigned LAST_PHASE = CLKS_PER_BIT - 1;

  line_t              meta_q;
  line_t              sync_q;
  line_t              line_q;
  line_t              prev_jk_q;
  line_t              line_c;
  logic [PHASE_W-1:0] phase_q;
  logic               jk_change_c;
  logic               sample_c;
  logic               strobe_q;
  logic               value_q;
  logic               se0_q;
  logic               j_q;

  // (1,1) is illegal on the bus and is folded into SE0
  always_comb begin
    line_c = sync_q;
    if (sync_q != LINE_J && sync_q != LINE_K) begin
      line_c = LINE_SE0;
    end
  end

  assign jk_change_c = ((line_c == LINE_J) && (line_q == LINE_K)) ||
                       ((line_c == LINE_K) && (line_q == LINE_J));
  assign sample_c    = (phase_q == PHASE_W'(SAMPLE_AT));

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q    <= LINE_J;
      sync_q    <= LINE_J;
      line_q    <= LINE_J;
      prev_jk_q <= LINE_J;
      phase_q   <= '0;
      strobe_q  <= 1'b0;
      value_q   <= 1'b0;
      se0_q     <= 1'b0;
      j_q       <= 1'b0;
    end else begin
      meta_q <= {d_plus_i, d_minus_i};
      sync_q <= meta_q;
      line_q <= line_c;

      if (jk_change_c || (phase_q == PHASE_W'(LAST_PHASE))) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_q + PHASE_W'(1);
      end

      strobe_q <= sample_c;
      se0_q    <= sample_c && (line_c == LINE_SE0);
      j_q      <= sample_c && (line_c == LINE_J);

      // NRZI: no change since the last J/K sample decodes as 1; SE0 leaves the reference alone
      if (sample_c) begin
        value_q <= (line_c == prev_jk_q);
        if (line_c != LINE_SE0) begin
          prev_jk_q <= line_c;
        end
      end
    end
  end

  assign bit_strobe_o = strobe_q;
  assign bit_value_o  = value_q;
  assign se0_sample_o = se0_q;
  assign j_sample_o   = j_q;

endmodule

// File: rtl/usb_rx_decoder.sv
// Full-speed USB receive decoder: bit unstuffing, SYNC/EOP framing and byte assembly
// on top of the line sampler. Bytes are delivered LSB-first-assembled in rx_data.
module usb_rx_decoder
  import usb_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_plus,
  input  logic              d_minus,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_data_valid,
  output logic              receiving,
  output logic              eop,
  output logic              rx_error
);

  localparam int unsigned CNT_W  = $clog2(BYTE_W);
  localparam int unsigned ONES_W = $clog2(STUFF_LIMIT + 1);
  localparam int unsigned JCNT_W = $clog2(ERR_J_EXIT);

  logic bit_strobe;
  logic bit_value;
  logic se0_sample;
  logic j_sample;

  usb_rx_bit_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .d_plus_i    (d_plus),
    .d_minus_i   (d_minus),
    .bit_strobe_o(bit_strobe),
    .bit_value_o (bit_value),
    .se0_sample_o(se0_sample),
    .j_sample_o  (j_sample)
  );

  rx_state_e         state_q;
  logic [BYTE_W-1:0] shift_q;
  logic [BYTE_W-1:0] shift_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [ONES_W-1:0] ones_q;
  logic [ONES_W-1:0] ones_d;
  logic [JCNT_W-1:0] j_cnt_q;
  logic              se0_seen_q;
  logic [BYTE_W-1:0] rx_data_q;
  logic              valid_q;
  logic              receiving_q;
  logic              eop_q;
  logic              err_q;

  logic jk_c;
  logic stuff_pos_c;
  logic stuff_err_c;
  logic data_bit_c;
  logic byte_done_c;

  // After STUFF_LIMIT ones the next J/K sample is a stuff slot: a 0 is dropped, a 1 is an error
  assign jk_c        = bit_strobe && !se0_sample;
  assign stuff_pos_c = (ones_q == ONES_W'(STUFF_LIMIT));
  assign stuff_err_c = jk_c && stuff_pos_c && bit_value;
  assign data_bit_c  = jk_c && !stuff_pos_c;
  assign byte_done_c = (bit_cnt_q == CNT_W'(BYTE_W - 1));
  assign shift_d     = {bit_value, shift_q[BYTE_W-1:1]};
  assign ones_d      = (stuff_pos_c || !bit_value) ? '0 : ones_q + ONES_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      j_cnt_q     <= '0;
      se0_seen_q  <= 1'b0;
      rx_data_q   <= '0;
      valid_q     <= 1'b0;
      receiving_q <= 1'b0;
      eop_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;

      case (state_q)
        // First K after idle is SYNC bit 0
        ST_IDLE: begin
          ones_q    <= '0;
          bit_cnt_q <= '0;
          if (jk_c && !bit_value) begin
            state_q     <= ST_SYNC;
            receiving_q <= 1'b1;
            shift_q     <= shift_d;
            bit_cnt_q   <= CNT_W'(1);
          end
        end

        ST_SYNC: begin
          if (se0_sample || stuff_err_c) begin
            state_q    <= ST_ERR;
            err_q      <= 1'b1;
            ones_q     <= '0;
            j_cnt_q    <= '0;
            se0_seen_q <= se0_sample;
          end else if (jk_c) begin
            ones_q <= ones_d;
            if (data_bit_c) begin
              shift_q <= shift_d;
              if (!byte_done_c) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end else if (shift_d == SYNC_BYTE) begin
                bit_cnt_q <= '0;
                state_q   <= ST_RECV;
              end else begin
                bit_cnt_q  <= '0;
                state_q    <= ST_ERR;
                err_q      <= 1'b1;
                ones_q     <= '0;
                j_cnt_q    <= '0;
                se0_seen_q <= 1'b0;
              end
            end
          end
        end

        // SE0 is only a legal EOP on a byte boundary
        ST_RECV: begin
          if (se0_sample && (bit_cnt_q == '0)) begin
            state_q <= ST_EOP;
            ones_q  <= '0;
          end else if (se0_sample || stuff_err_c) begin
            state_q    <= ST_ERR;
            err_q      <= 1'b1;
            ones_q     <= '0;
            j_cnt_q    <= '0;
            se0_seen_q <= se0_sample;
          end else if (jk_c) begin
            ones_q <= ones_d;
            if (data_bit_c) begin
              shift_q <= shift_d;
              if (byte_done_c) begin
                rx_data_q <= shift_d;
                valid_q   <= 1'b1;
                bit_cnt_q <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
            end
          end
        end

        ST_EOP: begin
          if (j_sample) begin
            eop_q       <= 1'b1;
            receiving_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (jk_c) begin
            state_q    <= ST_ERR;
            err_q      <= 1'b1;
            j_cnt_q    <= '0;
            se0_seen_q <= 1'b0;
          end
        end

        // Leave on SE0 followed by J, or after a long enough run of idle J
        ST_ERR: begin
          if (se0_sample) begin
            se0_seen_q <= 1'b1;
            j_cnt_q    <= '0;
          end else if (j_sample) begin
            if (se0_seen_q || (j_cnt_q == JCNT_W'(ERR_J_EXIT - 1))) begin
              state_q     <= ST_IDLE;
              receiving_q <= 1'b0;
              j_cnt_q     <= '0;
              se0_seen_q  <= 1'b0;
            end else begin
              j_cnt_q    <= j_cnt_q + JCNT_W'(1);
              se0_seen_q <= 1'b0;
            end
          end else if (bit_strobe) begin
            j_cnt_q    <= '0;
            se0_seen_q <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_data_valid = valid_q;
  assign receiving     = receiving_q;
  assign eop           = eop_q;
  assign rx_error      = err_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: an NRZI/bit-stuffing line encoder drives packets from a table,
// and a negedge monitor matches every valid/eop/error pulse against a scoreboard queue.
module tb_usb_rx_decoder;

  localparam int unsigned CPB = 8;
  localparam logic [1:0] TJ   = 2'b10;
  localparam logic [1:0] TK   = 2'b01;
  localparam logic [1:0] TSE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_plus = 1'b1;
  logic       d_minus = 1'b0;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       receiving;
  logic       eop;
  logic       rx_error;

  usb_rx_decoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .d_plus       (d_plus),
    .d_minus      (d_minus),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .receiving    (receiving),
    .eop          (eop),
    .rx_error     (rx_error)
  );

  always #5 clk = ~clk;

  typedef enum {EV_BYTE, EV_EOP, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
  } ev_t;

  // mode 0: normal packet, 1: unstuffed run of ones, 2: SE0 after 3 bits of 'partial'
  typedef struct {
    string      name;
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b1;
    int         mode;
    logic [7:0] partial;
    logic       exp_eop;
    logic [7:0] exp_data;
  } vec_t;

  ev_t        exp_q[$];
  vec_t       vecs[5];
  int         n_checks = 0;
  int         n_pass = 0;
  logic [1:0] cur_line = TJ;
  int         ones_run = 0;

  function automatic vec_t mk(string n, int nb, logic [7:0] b0, logic [7:0] b1, int m,
                              logic [7:0] p, logic e, logic [7:0] d);
    vec_t v;
    v.name = n; v.nbytes = nb; v.b0 = b0; v.b1 = b1; v.mode = m;
    v.partial = p; v.exp_eop = e; v.exp_data = d;
    return v;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
  endtask

  task automatic push(input ev_kind_e k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input logic [7:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_%s: got data %02h, expected no event", k.name(), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == k && (k != EV_BYTE || e.data == d)) n_pass++;
      else $display("FAIL event_order: got %s/%02h, expected %s/%02h", k.name(), d,
                    e.kind.name(), e.data);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_data_valid) observe(EV_BYTE, rx_data);
      if (eop)           observe(EV_EOP, 8'h00);
      if (rx_error)      observe(EV_ERR, 8'h00);
    end
  end

  task automatic drive_line(input logic [1:0] ls);
    {d_plus, d_minus} = ls;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_raw(input logic b);
    if (!b) cur_line = (cur_line == TJ) ? TK : TJ;
    drive_line(cur_line);
  endtask

  task automatic send_bit(input logic b);
    send_raw(b);
    if (b) ones_run++;
    else ones_run = 0;
    if (ones_run == 6) begin
      send_raw(1'b0);
      ones_run = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(v[i]);
  endtask

  task automatic start_packet();
    cur_line = TJ;
    ones_run = 0;
  endtask

  task automatic trailer();
    drive_line(TSE0);
    drive_line(TSE0);
    repeat (4) drive_line(TJ);
    cur_line = TJ;
    ones_run = 0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check(nm, 8'(exp_q.size()), 8'h00);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = mk("pkt_6e",          1, 8'h6E, 8'h00, 0, 8'h00, 1'b1, 8'h6E);
    vecs[1] = mk("pkt_ff_3f",       2, 8'hFF, 8'h3F, 0, 8'h00, 1'b1, 8'h3F);
    vecs[2] = mk("stuff_violation", 0, 8'h00, 8'h00, 1, 8'h00, 1'b0, 8'h3F);
    vecs[3] = mk("pkt_c3",          1, 8'hC3, 8'h00, 0, 8'h00, 1'b1, 8'hC3);
    vecs[4] = mk("se0_midbyte",     1, 8'h5A, 8'h00, 2, 8'h07, 1'b0, 8'h5A);

    {d_plus, d_minus} = TJ;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data",   rx_data, 8'h00);
    check("reset_valid",     8'(rx_data_valid), 8'h00);
    check("reset_receiving", 8'(receiving), 8'h00);
    check("reset_eop",       8'(eop), 8'h00);
    check("reset_error",     8'(rx_error), 8'h00);
    rst = 1'b0;
    repeat (4) drive_line(TJ);

    for (int v = 0; v < 5; v++) begin
      start_packet();
      send_byte(8'h80, 8);
      check({vecs[v].name, "_recv_sync"}, 8'(receiving), 8'h01);
      for (int b = 0; b < vecs[v].nbytes; b++) begin
        push(EV_BYTE, (b == 0) ? vecs[v].b0 : vecs[v].b1);
        send_byte((b == 0) ? vecs[v].b0 : vecs[v].b1, 8);
      end
      if (vecs[v].mode == 1) begin
        push(EV_ERR, 8'h00);
        repeat (7) send_raw(1'b1);
      end else if (vecs[v].mode == 2) begin
        send_byte(vecs[v].partial, 3);
        push(EV_ERR, 8'h00);
      end
      if (vecs[v].exp_eop) push(EV_EOP, 8'h00);
      trailer();
      wait_drain({vecs[v].name, "_events"});
      check({vecs[v].name, "_recv_end"}, 8'(receiving), 8'h00);
      check({vecs[v].name, "_rx_data"}, rx_data, vecs[v].exp_data);
    end

    // Bad SYNC decoding to 8'h40, then exit only after the 8th idle J
    start_packet();
    push(EV_ERR, 8'h00);
    send_byte(8'h40, 8);
    check("bad_sync_recv_err", 8'(receiving), 8'h01);
    repeat (7) drive_line(TJ);
    check("bad_sync_recv_7j", 8'(receiving), 8'h01);
    drive_line(TJ);
    check("bad_sync_recv_8j", 8'(receiving), 8'h00);
    wait_drain("bad_sync_events");
    check("bad_sync_rx_data", rx_data, 8'h5A);

    // Reset in the middle of a byte, then a clean packet
    start_packet();
    send_byte(8'h80, 8);
    send_byte(8'h3C, 4);
    rst = 1'b1;
    {d_plus, d_minus} = TJ;
    @(negedge clk);
    check("midrst_rx_data",   rx_data, 8'h00);
    check("midrst_valid",     8'(rx_data_valid), 8'h00);
    check("midrst_receiving", 8'(receiving), 8'h00);
    check("midrst_eop",       8'(eop), 8'h00);
    check("midrst_error",     8'(rx_error), 8'h00);
    rst = 1'b0;
    repeat (4) drive_line(TJ);
    wait_drain("midrst_no_events");
    start_packet();
    send_byte(8'h80, 8);
    check("after_rst_recv_sync", 8'(receiving), 8'h01);
    push(EV_BYTE, 8'hA5);
    send_byte(8'hA5, 8);
    push(EV_EOP, 8'h00);
    trailer();
    wait_drain("after_rst_events");
    check("after_rst_recv_end", 8'(receiving), 8'h00);
    check("after_rst_rx_data", rx_data, 8'hA5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
